gain_shifter: RTL and testbench
===============================

# gain_shifter

Parametrised, multi-channel successor to the single-channel constant shift gain. Applies a per-channel programmable power-of-two gain (amplify by left shift or attenuate by arithmetic right shift) to a stream of signed, channel-tagged samples. The stage is pipelined with valid/ready handshakes, saturates instead of wrapping on overflow, and exposes sticky per-channel saturation flags. It sits between the front-end sample source and the downstream filter/correlator chain.

## Interface
- W, 16: sample width, signed two's complement.
- NCH, 4: channel count, ≥2; CHW = $clog2(NCH).
- SHW, 4: shift-amount field width.
- ROUND, 0: 1 = round-half-up on right shifts; 0 = floor.
- clk  in  1  single clock; all logic on rising edge.
- rstn  in  1  asynchronous active-low reset.
- cfg_we  in  1  write the gain register of channel cfg_ch.
- cfg_ch  in  CHW  channel selected for configuration.
- cfg_shift  in  SHW  shift amount.
- cfg_dir  in  1  0 = left shift (amplify), 1 = right shift (attenuate).
- in_valid / in_ready  in / out  1  input handshake.
- in_ch  in  CHW  input channel tag.
- in_data  in  W  signed input sample.
- out_valid / out_ready  out / in  1  output handshake.
- out_ch  out  CHW  channel tag of the output sample.
- out_data  out  W  signed scaled sample.
- out_sat  out  1  current output sample was saturated.
- sat_flags  out  NCH  sticky per-channel saturation flags.
- sat_clr  in  1  one-cycle pulse that clears all sat_flags.

## Operation
- Gain register file: NCH entries of {dir, shift}. Reset value is {0,0}, which is unity gain. An entry is written on the rising edge when cfg_we=1. An out-of-range cfg_ch (≥NCH) is ignored.
- Stage 1 (S1) captures in_data and in_ch on an input transfer (in_valid && in_ready). In the same edge it captures the gain entry for in_ch.
  - The captured gain is the entry value before that edge. A cfg write to the same channel in the same cycle affects only later samples.
  - An out-of-range in_ch uses gain {0,0}.
- Stage 2 (S2) computes the scaled value from the S1 contents and registers out_data, out_ch and out_sat.
- Left shift, s = min(shift, W-1):
  - The exact result is computed at W+s bits.
  - If it exceeds 2^(W-1)-1, output 2^(W-1)-1 with sat=1.
  - If it is below -2^(W-1), output -2^(W-1) with sat=1.
  - Otherwise output the exact result with sat=0.
  - Shift 0 passes the sample through with sat=0.
- Right shift:
  - shift ≥ W: output is sign fill (0 for non-negative input, -1 for negative) when ROUND=0, and 0 when ROUND=1.
  - ROUND=1 adds 2^(shift-1) before the shift, computed at W+1 bits. A result above 2^(W-1)-1 clamps there with sat=1; this case can only arise for shift=0, and shift=0 adds nothing.
  - A right shift never sets sat in any other case.
- sat_flags[out_ch] is set on the edge where S2 loads a sample with sat=1.
  - sat_clr clears all flags.
  - If a set and sat_clr occur in the same cycle, the set wins for that channel.

## Timing
- Latency is 2 cycles from input transfer to out_valid, with no stalls.
- Throughput is 1 sample/cycle while out_ready=1.
- Stall rules:
  - s2_adv = !out_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv, which is combinational from out_ready. There is no combinational path from in_valid to in_ready.
- While out_valid && !out_ready, out_data, out_ch and out_sat hold stable.
- out_valid never drops without a transfer.
- Reset values: out_valid=0, out_data=0, out_ch=0, out_sat=0, sat_flags=0, S1 empty, all gain entries {0,0}. in_ready=1 during and after reset.
- Reset asserted mid-stream discards in-flight samples immediately; no output transfer completes afterwards.
- cfg writes are accepted every cycle regardless of stall state.

## Structure
- Shared package gain_pkg holds:
  - the gain entry struct {dir, shift};
  - the constants GAIN_UNITY and DIR_LEFT/DIR_RIGHT;
  - the saturation limit functions sat_max(W) and sat_min(W).
- The sub-module sat_shift is purely combinational.
  - Inputs: data, dir, shift, ROUND.
  - Outputs: result, sat.
  - It is instantiated in S2 and unit-tested on its own.
- Everything else (gain register file, S1/S2 registers, flags) lives in the top level.

## Test plan
- Reset, then ch0 left 3, in_data=0x0100 -> out_data=0x0800 two cycles after the transfer, out_sat=0, sat_flags=0.
- ch1 left 4, in_data=0x1000 -> 0x7FFF, out_sat=1, sat_flags[1]=1. in_data=0xF000 (-4096) on ch1 -> 0x8000, out_sat=1.
- ch2 right 2, in_data=-5 (0xFFFB):
  - ROUND=0 -> 0xFFFE (-2);
  - ROUND=1 -> 0xFFFF (-1);
  - right 20 on positive input -> 0x0000.
- Back-to-back burst of 8 samples across all channels with out_ready toggling 1,0,0,1 -> no sample lost, duplicated or reordered; outputs stable while stalled; in_ready=0 only when both stages are full and out_ready=0.
- cfg write to ch0 (left 1 -> left 2) in the same cycle as a ch0 input transfer -> that sample uses left 1, the next uses left 2. sat_clr in the same cycle as a new saturation on ch3 -> sat_flags=4'b1000.
- Assert rstn low with 2 samples in flight -> out_valid=0 immediately. After release: gains are unity, a sample 0x1234 passes unchanged, and in_ready=1.

Source files
------------

// File: rtl/gain_pkg.sv
// Shared types and helpers for the gain_shifter stage: gain entry layout,
// shift direction encodings and signed saturation limits.
package gain_pkg;

  localparam int GAIN_SHW = 8;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef struct packed {
    logic                dir;
    logic [GAIN_SHW-1:0] shift;
  } gain_t;

  localparam gain_t GAIN_UNITY = '{dir: DIR_LEFT, shift: '0};

  function automatic longint sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/sat_shift.sv
// Combinational power-of-two scaler: saturating left shift, or arithmetic
// right shift with optional round-half-up.
module sat_shift
  import gain_pkg::*;
#(
  parameter int W     = 16,
  parameter int SHW   = 4,
  parameter bit ROUND = 1'b0
) (
  input  logic [W-1:0]   data,
  input  logic           dir,
  input  logic [SHW-1:0] shift,
  output logic [W-1:0]   result,
  output logic           sat
);

  localparam longint MAXV = sat_max(W);
  localparam longint MINV = sat_min(W);

  logic signed [2*W-1:0] wide;
  logic signed [W:0]     rnd_add;
  logic signed [W:0]     rnd_sum;
  logic signed [W:0]     rnd_res;
  int unsigned           sh_u;
  int unsigned           sl_u;

  always_comb begin
    sh_u = 32'(shift);
    sl_u = (sh_u > 32'(W - 1)) ? 32'(W - 1) : sh_u;
    // Left shift is clamped to W-1 so 2W bits always hold the exact product.
    wide = (2*W)'($signed(data)) <<< sl_u;

    rnd_add = '0;
    if (ROUND && (sh_u != 0) && (sh_u < 32'(W)))
      rnd_add = (W+1)'(1) << (sh_u - 1);
    rnd_sum = $signed({data[W-1], data}) + rnd_add;
    rnd_res = rnd_sum >>> sh_u;

    result = data;
    sat    = 1'b0;
    if (dir == DIR_RIGHT) begin
      if (sh_u >= 32'(W)) begin
        result = (ROUND || !data[W-1]) ? '0 : '1;
      end else if (longint'(rnd_res) > MAXV) begin
        result = W'(MAXV);
        sat    = 1'b1;
      end else begin
        result = rnd_res[W-1:0];
      end
    end else begin
      if (longint'(wide) > MAXV) begin
        result = W'(MAXV);
        sat    = 1'b1;
      end else if (longint'(wide) < MINV) begin
        result = W'(MINV);
        sat    = 1'b1;
      end else begin
        result = wide[W-1:0];
      end
    end
  end

endmodule

// File: rtl/gain_shifter.sv
// Multi-channel programmable power-of-two gain stage: per-channel gain file,
// two-stage valid/ready pipeline, saturation and sticky per-channel flags.
module gain_shifter
  import gain_pkg::*;
#(
  parameter int W     = 16,
  parameter int NCH   = 4,
  parameter int CHW   = $clog2(NCH),
  parameter int SHW   = 4,
  parameter bit ROUND = 1'b0
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           cfg_we,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [SHW-1:0] cfg_shift,
  input  logic           cfg_dir,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [CHW-1:0] in_ch,
  input  logic [W-1:0]   in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [CHW-1:0] out_ch,
  output logic [W-1:0]   out_data,
  output logic           out_sat,
  output logic [NCH-1:0] sat_flags,
  input  logic           sat_clr
);

  gain_t          gain_q [NCH];
  gain_t          gain_rd;

  logic           s1_valid_q;
  logic [W-1:0]   s1_data_q;
  logic [CHW-1:0] s1_ch_q;
  gain_t          s1_gain_q;

  logic           out_valid_q;
  logic [CHW-1:0] out_ch_q;
  logic [W-1:0]   out_data_q;
  logic           out_sat_q;
  logic [NCH-1:0] flags_q;
  logic [NCH-1:0] flags_d;

  logic           s1_adv;
  logic           s2_adv;
  logic           s2_load;
  logic [W-1:0]   calc_data;
  logic           calc_sat;

  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign s2_load  = s2_adv && s1_valid_q;
  assign in_ready = s1_adv;

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign sat_flags = flags_q;

  // Read sees the pre-edge entry, so a same-cycle write only affects later samples.
  always_comb begin
    gain_rd = GAIN_UNITY;
    if (int'(in_ch) < NCH)
      gain_rd = gain_q[in_ch];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NCH; i++)
        gain_q[i] <= GAIN_UNITY;
    end else if (cfg_we && (int'(cfg_ch) < NCH)) begin
      gain_q[cfg_ch] <= '{dir: cfg_dir, shift: GAIN_SHW'(cfg_shift)};
    end
  end

  sat_shift #(
    .W     (W),
    .SHW   (GAIN_SHW),
    .ROUND (ROUND)
  ) u_sat_shift (
    .data   (s1_data_q),
    .dir    (s1_gain_q.dir),
    .shift  (s1_gain_q.shift),
    .result (calc_data),
    .sat    (calc_sat)
  );

  // A new saturation outranks a simultaneous clear on its own channel.
  always_comb begin
    flags_d = sat_clr ? '0 : flags_q;
    if (s2_load && calc_sat && (int'(s1_ch_q) < NCH))
      flags_d[s1_ch_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_ch_q     <= '0;
      s1_gain_q   <= GAIN_UNITY;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      flags_q     <= '0;
    end else begin
      flags_q <= flags_d;
      if (s1_adv) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_data_q <= in_data;
          s1_ch_q   <= in_ch;
          s1_gain_q <= gain_rd;
        end
      end
      if (s2_adv) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_data_q <= calc_data;
          out_ch_q   <= s1_ch_q;
          out_sat_q  <= calc_sat;
        end
      end
    end
  end

endmodule

// File: tb/tb_gain_shifter.sv
// Directed bench for gain_shifter plus standalone sat_shift units covering
// rounding and wide-shift corner cases.
module tb_gain_shifter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [3:0]  cfg_shift;
  logic        cfg_dir;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_ch;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_ch;
  logic [15:0] out_data;
  logic        out_sat;
  logic [3:0]  sat_flags;
  logic        sat_clr;

  logic [15:0] u_data;
  logic        u_dir;
  logic [4:0]  u_shift;
  logic [15:0] u_res0;
  logic [15:0] u_res1;
  logic        u_sat0;
  logic        u_sat1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gain_shifter #(.W(16), .NCH(4), .SHW(4), .ROUND(1'b0)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_shift (cfg_shift),
    .cfg_dir   (cfg_dir),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ch     (in_ch),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .sat_flags (sat_flags),
    .sat_clr   (sat_clr)
  );

  sat_shift #(.W(16), .SHW(5), .ROUND(1'b0)) u_r0 (
    .data (u_data), .dir (u_dir), .shift (u_shift), .result (u_res0), .sat (u_sat0)
  );

  sat_shift #(.W(16), .SHW(5), .ROUND(1'b1)) u_r1 (
    .data (u_data), .dir (u_dir), .shift (u_shift), .result (u_res1), .sat (u_sat1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic [1:0] ch, input logic dir, input logic [3:0] sh);
    cfg_we = 1'b1; cfg_ch = ch; cfg_dir = dir; cfg_shift = sh;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Single sample through an empty pipeline with out_ready held high.
  task automatic xfer(input string tag, input logic [1:0] ch, input logic [15:0] d,
                      input logic [15:0] exp_d, input logic exp_s);
    chk({tag, " in_ready"}, in_ready, 1);
    in_valid = 1'b1; in_ch = ch; in_data = d;
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, " latency1 valid"}, out_valid, 0);
    @(negedge clk);
    chk({tag, " valid"}, out_valid, 1);
    chk({tag, " data"}, out_data, exp_d);
    chk({tag, " ch"}, out_ch, ch);
    chk({tag, " sat"}, out_sat, exp_s);
    @(negedge clk);
  endtask

  task automatic uchk(input string tag, input logic [15:0] d, input logic dir,
                      input logic [4:0] sh, input logic [15:0] e0, input logic [15:0] e1,
                      input logic es);
    u_data = d; u_dir = dir; u_shift = sh;
    #1;
    chk({tag, " r0 result"}, u_res0, e0);
    chk({tag, " r1 result"}, u_res1, e1);
    chk({tag, " r0 sat"}, u_sat0, es);
    chk({tag, " r1 sat"}, u_sat1, es);
  endtask

  logic [1:0]  b_ch  [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
  logic [15:0] b_dat [8] = '{16'h0001, 16'h0002, 16'h0010, 16'h0123,
                             16'hFFFF, 16'hFFF0, 16'hFFF0, 16'h8000};
  logic [15:0] b_exp [8] = '{16'h0008, 16'h0020, 16'h0004, 16'h0123,
                             16'hFFF8, 16'hFF00, 16'hFFFC, 16'h8000};
  logic        pat   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  int   sent;
  int   rcv;
  int   occ;
  logic acc;
  logic dlv;
  logic was_stalled;

  initial begin
    rstn = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_shift = '0; cfg_dir = 1'b0;
    in_valid = 1'b0; in_ch = '0; in_data = '0; out_ready = 1'b0; sat_clr = 1'b0;
    u_data = '0; u_dir = 1'b0; u_shift = '0;

    repeat (3) @(negedge clk);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_data", out_data, 0);
    chk("rst out_ch", out_ch, 0);
    chk("rst out_sat", out_sat, 0);
    chk("rst sat_flags", sat_flags, 0);
    chk("rst in_ready", in_ready, 1);
    rstn = 1'b1; out_ready = 1'b1;
    @(negedge clk);

    cfg(2'd0, 1'b0, 4'd3);
    xfer("ch0 L3", 2'd0, 16'h0100, 16'h0800, 1'b0);
    chk("ch0 L3 flags", sat_flags, 4'b0000);

    cfg(2'd1, 1'b0, 4'd4);
    xfer("ch1 L4 pos", 2'd1, 16'h1000, 16'h7FFF, 1'b1);
    chk("ch1 L4 flags", sat_flags, 4'b0010);
    xfer("ch1 L4 neg", 2'd1, 16'hF000, 16'h8000, 1'b1);

    cfg(2'd2, 1'b1, 4'd2);
    xfer("ch2 R2", 2'd2, 16'hFFFB, 16'hFFFE, 1'b0);

    uchk("u R2 -5", 16'hFFFB, 1'b1, 5'd2, 16'hFFFE, 16'hFFFF, 1'b0);
    uchk("u R20 pos", 16'h1234, 1'b1, 5'd20, 16'h0000, 16'h0000, 1'b0);
    uchk("u R20 neg", 16'h8000, 1'b1, 5'd20, 16'hFFFF, 16'h0000, 1'b0);
    uchk("u R1 max", 16'h7FFF, 1'b1, 5'd1, 16'h3FFF, 16'h4000, 1'b0);
    uchk("u R2 6", 16'h0006, 1'b1, 5'd2, 16'h0001, 16'h0002, 1'b0);
    uchk("u R2 -6", 16'hFFFA, 1'b1, 5'd2, 16'hFFFE, 16'hFFFF, 1'b0);
    uchk("u R0", 16'hFFFF, 1'b1, 5'd0, 16'hFFFF, 16'hFFFF, 1'b0);
    uchk("u L20 one", 16'h0001, 1'b0, 5'd20, 16'h7FFF, 16'h7FFF, 1'b1);
    uchk("u L1 below max", 16'h3FFF, 1'b0, 5'd1, 16'h7FFE, 16'h7FFE, 1'b0);
    uchk("u L1 exact min", 16'hC000, 1'b0, 5'd1, 16'h8000, 16'h8000, 1'b0);
    uchk("u L1 below min", 16'hBFFF, 1'b0, 5'd1, 16'h8000, 16'h8000, 1'b1);
    uchk("u L0 pass", 16'h8000, 1'b0, 5'd0, 16'h8000, 16'h8000, 1'b0);
    @(negedge clk);

    // Burst across all channels while out_ready cycles 1,0,0,1.
    sent = 0; rcv = 0; occ = 0; was_stalled = 1'b0;
    for (int c = 0; c < 60 && rcv < 8; c++) begin
      out_ready = pat[c % 4];
      if (sent < 8) begin
        in_valid = 1'b1; in_ch = b_ch[sent]; in_data = b_dat[sent];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      chk("burst in_ready", in_ready, !(occ == 2 && !out_ready));
      if (was_stalled)
        chk("burst valid hold", out_valid, 1);
      if (out_valid) begin
        chk("burst data", out_data, b_exp[rcv]);
        chk("burst ch", out_ch, b_ch[rcv]);
        chk("burst sat", out_sat, 0);
      end
      acc = in_valid && in_ready;
      dlv = out_valid && out_ready;
      was_stalled = out_valid && !out_ready;
      if (dlv) rcv++;
      if (acc) sent++;
      occ = occ + int'(acc) - int'(dlv);
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("burst delivered", rcv, 8);
    chk("burst drained", out_valid, 0);
    chk("burst flags", sat_flags, 4'b0010);

    // Same-cycle cfg write and input on ch0.
    cfg(2'd0, 1'b0, 4'd1);
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_dir = 1'b0; cfg_shift = 4'd2;
    in_valid = 1'b1; in_ch = 2'd0; in_data = 16'h0100;
    @(negedge clk);
    cfg_we = 1'b0;
    in_valid = 1'b1; in_ch = 2'd0; in_data = 16'h0100;
    @(negedge clk);
    in_valid = 1'b0;
    chk("cfg race old valid", out_valid, 1);
    chk("cfg race old gain", out_data, 16'h0200);
    @(negedge clk);
    chk("cfg race new valid", out_valid, 1);
    chk("cfg race new gain", out_data, 16'h0400);
    @(negedge clk);

    // sat_clr coinciding with a fresh saturation on ch3.
    cfg(2'd3, 1'b0, 4'd15);
    in_valid = 1'b1; in_ch = 2'd3; in_data = 16'h0001;
    @(negedge clk);
    in_valid = 1'b0; sat_clr = 1'b1;
    @(negedge clk);
    sat_clr = 1'b0;
    chk("clr race data", out_data, 16'h7FFF);
    chk("clr race sat", out_sat, 1);
    chk("clr race flags", sat_flags, 4'b1000);
    @(negedge clk);
    sat_clr = 1'b1;
    @(negedge clk);
    sat_clr = 1'b0;
    chk("clr alone flags", sat_flags, 4'b0000);

    // Fill both stages under stall, then reset mid-stream.
    out_ready = 1'b0;
    in_valid = 1'b1; in_ch = 2'd0; in_data = 16'h0011;
    @(negedge clk);
    in_valid = 1'b1; in_ch = 2'd1; in_data = 16'h0022;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("full in_ready", in_ready, 0);
    chk("full out_valid", out_valid, 1);
    chk("full out_data", out_data, 16'h0044);
    rstn = 1'b0;
    #1;
    chk("midrst out_valid", out_valid, 0);
    chk("midrst in_ready", in_ready, 1);
    @(negedge clk);
    @(negedge clk);
    out_ready = 1'b1; rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post rst no output", out_valid, 0);
    end
    xfer("post rst ch0", 2'd0, 16'h1234, 16'h1234, 1'b0);
    xfer("post rst ch1", 2'd1, 16'h1234, 16'h1234, 1'b0);
    chk("post rst flags", sat_flags, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
